// File: rtl/tdm_domain_fsm_pkg.sv
// rtl/tdm_domain_fsm_pkg.sv - shared domain encodings and label helper for tdm_domain_fsm
package tdm_domain_fsm_pkg;

    typedef enum logic {
        MODE_L = 1'b0,
        MODE_H = 1'b1
    } mode_e;

    typedef enum logic {
        LBL_L = 1'b0,
        LBL_H = 1'b1
    } label_e;

    localparam int STATE_L          = 0;
    localparam int DEFAULT_SLOT_LEN = 10;

    // Security label of a cur_state value: only state 0 is public.
    function automatic label_e par_label(input int unsigned state);
        return (state == STATE_L) ? LBL_L : LBL_H;
    endfunction

endpackage

// File: rtl/tdm_domain_fsm_slot_timer_ctr.sv
// rtl/tdm_domain_fsm_slot_timer_ctr.sv - public reload/down-counter that paces slot switches
module tdm_domain_fsm_slot_timer_ctr #(
    parameter int SLOT_LEN = 10,
    parameter int TIMER_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TIMER_W-1:0] slot_timer,
    output logic               expire
);

    assign expire = (slot_timer == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_timer <= TIMER_W'(SLOT_LEN);
        end else if (expire) begin
            slot_timer <= TIMER_W'(SLOT_LEN);
        end else begin
            slot_timer <= slot_timer - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/tdm_domain_fsm.sv
// rtl/tdm_domain_fsm.sv - timer-switched L/H time-division domain FSM with H scrub on exit
module tdm_domain_fsm
    import tdm_domain_fsm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SLOT_LEN = DEFAULT_SLOT_LEN,
    parameter int TIMER_W  = 16,
    parameter int NUM_H    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   l_in,
    input  logic               l_in_valid,
    input  logic [WIDTH-1:0]   h_in,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               mode,
    output logic [TIMER_W-1:0] slot_timer,
    output logic [WIDTH-1:0]   h_out
);

    localparam int SW = $clog2(NUM_H + 1);
    localparam logic [SW-1:0] ST_L       = SW'(STATE_L);
    localparam logic [SW-1:0] ST_FIRST_H = SW'(1);
    localparam logic [SW-1:0] ST_LAST_H  = SW'(NUM_H);

    logic              expire;
    mode_e             mode_q, mode_d;
    logic [SW-1:0]     cur_state, state_d;
    logic [WIDTH-1:0]  h_acc, acc_d;
    logic [WIDTH-1:0]  out_d;
    logic              out_valid_d;

    tdm_domain_fsm_slot_timer_ctr #(
        .SLOT_LEN (SLOT_LEN),
        .TIMER_W  (TIMER_W)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .slot_timer (slot_timer),
        .expire     (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_L;
            cur_state <= ST_L;
            h_acc     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cur_state <= state_d;
            h_acc     <= acc_d;
            out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

    // Public outputs depend only on mode, timer and l_in; H data only reaches h_acc/cur_state.
    always_comb begin
        mode_d      = mode_q;
        state_d     = cur_state;
        acc_d       = h_acc;
        out_d       = out;
        out_valid_d = 1'b0;

        if (expire) begin
            if (mode_q == MODE_L) begin
                mode_d  = MODE_H;
                state_d = ST_FIRST_H;
            end else begin
                mode_d  = MODE_L;
                state_d = ST_L;
                acc_d   = '0;
            end
        end else begin
            if (mode_q == MODE_L && l_in_valid) begin
                out_d       = l_in;
                out_valid_d = 1'b1;
            end

            if (cur_state > ST_LAST_H) begin
                state_d = ST_L;
                acc_d   = '0;
            end else if (cur_state != ST_L && h_in != '0) begin
                acc_d   = h_acc + h_in;
                state_d = (cur_state == ST_LAST_H) ? ST_FIRST_H : cur_state + SW'(1);
            end
        end
    end

    assign mode  = mode_q;
    assign h_out = h_acc;

endmodule

// File: tb/tb_tdm_domain_fsm.sv
// tb/tb_tdm_domain_fsm.sv - self-checking bench for tdm_domain_fsm
module tb_tdm_domain_fsm;

    localparam int WIDTH    = 16;
    localparam int SLOT_LEN = 10;
    localparam int TIMER_W  = 16;
    localparam int NUM_H    = 2;
    localparam int NTBL     = 24;
    localparam int NRAND    = 200;

    logic               clk = 1'b0;
    logic               reset;
    logic [WIDTH-1:0]   l_in, h_in, out, h_out;
    logic               l_in_valid, out_valid, mode;
    logic [TIMER_W-1:0] slot_timer;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_domain_fsm #(
        .WIDTH    (WIDTH),
        .SLOT_LEN (SLOT_LEN),
        .TIMER_W  (TIMER_W),
        .NUM_H    (NUM_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_in       (l_in),
        .l_in_valid (l_in_valid),
        .h_in       (h_in),
        .out        (out),
        .out_valid  (out_valid),
        .mode       (mode),
        .slot_timer (slot_timer),
        .h_out      (h_out)
    );

    typedef struct {
        logic        lv;
        logic [15:0] li;
        logic [15:0] hi;
        logic        eout_v;
        logic [15:0] eout;
        logic        emode;
        int          etimer;
        logic [15:0] ehout;
        int          estate;
    } vec_t;

    vec_t tbl[NTBL];

    logic [15:0] ls_in [NRAND];
    logic        ls_v  [NRAND];
    logic [33:0] trace [2][NRAND];

    int          m_n;
    logic [15:0] m_out;
    logic        m_valid;
    logic [15:0] m_acc;
    int          m_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        l_in       = '0;
        l_in_valid = 1'b0;
        h_in       = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Schedule is a pure function of cycles elapsed since reset.
    function automatic int exp_mode(input int n);
        return (n / (SLOT_LEN + 1)) % 2;
    endfunction

    function automatic int exp_timer(input int n);
        return SLOT_LEN - (n % (SLOT_LEN + 1));
    endfunction

    task automatic model_reset;
        m_n = 0; m_out = '0; m_valid = 1'b0; m_acc = '0; m_k = 0;
    endtask

    task automatic model_step(input logic lv, input logic [15:0] li, input logic [15:0] hi);
        if (exp_timer(m_n) == 0) begin
            m_valid = 1'b0;
            m_k     = 0;
            if (exp_mode(m_n) == 1) m_acc = '0;
        end else if (exp_mode(m_n) == 0) begin
            m_valid = lv;
            if (lv) m_out = li;
        end else begin
            m_valid = 1'b0;
            if (hi != 0) begin
                m_acc = m_acc + hi;
                m_k++;
            end
        end
        m_n++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out"},   32'(out),        32'(m_out));
        chk({tag, "_valid"}, 32'(out_valid),  32'(m_valid));
        chk({tag, "_mode"},  32'(mode),       32'(exp_mode(m_n)));
        chk({tag, "_timer"}, 32'(slot_timer), 32'(exp_timer(m_n)));
        chk({tag, "_hout"},  32'(h_out),      32'(m_acc));
        chk({tag, "_state"}, 32'(dut.cur_state),
            (exp_mode(m_n) == 1) ? 32'(1 + (m_k % NUM_H)) : 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NTBL; i++) begin
            int j;
            j = i + 1;
            tbl[i].lv     = (i == 3) || (i == 10);
            tbl[i].li     = (i == 3) ? 16'h00AB : (i == 10) ? 16'h1234 : 16'h5555;
            tbl[i].hi     = (i >= 11 && i <= 20) ? 16'd3 : (i == 21) ? 16'd5 : 16'd9;
            tbl[i].eout_v = (j == 4);
            tbl[i].eout   = (j >= 4) ? 16'h00AB : 16'h0000;
            tbl[i].emode  = (j >= 11 && j <= 21);
            tbl[i].etimer = 10 - (j % 11);
            tbl[i].ehout  = (j >= 11 && j <= 21) ? 16'(3 * (j - 11)) : 16'h0000;
            tbl[i].estate = (j >= 11 && j <= 21) ? 1 + ((j - 11) % 2) : 0;
        end

        do_reset();
        chk("rst_out",   32'(out),            32'd0);
        chk("rst_valid", 32'(out_valid),      32'd0);
        chk("rst_mode",  32'(mode),           32'd0);
        chk("rst_timer", 32'(slot_timer),     32'd10);
        chk("rst_hout",  32'(h_out),          32'd0);
        chk("rst_state", 32'(dut.cur_state),  32'd0);

        for (int i = 0; i < NTBL; i++) begin
            l_in       = tbl[i].li;
            l_in_valid = tbl[i].lv;
            h_in       = tbl[i].hi;
            tick();
            chk($sformatf("tbl%0d_out", i),   32'(out),           32'(tbl[i].eout));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid),     32'(tbl[i].eout_v));
            chk($sformatf("tbl%0d_mode", i),  32'(mode),          32'(tbl[i].emode));
            chk($sformatf("tbl%0d_timer", i), 32'(slot_timer),    32'(tbl[i].etimer));
            chk($sformatf("tbl%0d_hout", i),  32'(h_out),         32'(tbl[i].ehout));
            chk($sformatf("tbl%0d_state", i), 32'(dut.cur_state), 32'(tbl[i].estate));
        end

        // Reset asserted in the middle of an H slot.
        begin
            int guard;
            do_reset();
            l_in       = 16'h00CD;
            l_in_valid = 1'b1;
            tick();
            l_in_valid = 1'b0;
            h_in       = 16'd7;
            guard      = 0;
            while (!(mode == 1'b1 && slot_timer == 4) && guard < 100) begin
                tick();
                guard++;
            end
            chk("midh_reach", 32'(guard < 100), 32'd1);
            chk("midh_acc_busy", 32'(h_out != 0), 32'd1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("midh_mode",  32'(mode),           32'd0);
            chk("midh_state", 32'(dut.cur_state),  32'd0);
            chk("midh_timer", 32'(slot_timer),     32'd10);
            chk("midh_hout",  32'(h_out),          32'd0);
            chk("midh_out",   32'(out),            32'd0);
            chk("midh_valid", 32'(out_valid),      32'd0);
            h_in = '0;
        end

        // Same l_in stream, two different h_in streams; both against the model.
        for (int c = 0; c < NRAND; c++) begin
            ls_in[c] = 16'($urandom);
            ls_v[c]  = 1'($urandom_range(0, 1));
        end
        for (int r = 0; r < 2; r++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < NRAND; c++) begin
                l_in       = ls_in[c];
                l_in_valid = ls_v[c];
                h_in       = (r == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                model_step(l_in_valid, l_in, h_in);
                tick();
                check_model($sformatf("rnd%0d_c%0d", r, c));
                trace[r][c] = {out, out_valid, mode, slot_timer};
            end
        end
        for (int c = 0; c < NRAND; c++) begin
            chk($sformatf("nonint_c%0d", c), 32'(trace[1][c][31:0] ^ trace[0][c][31:0]), 32'd0);
            chk($sformatf("nonint_hi_c%0d", c), 32'(trace[1][c][33:32]), 32'(trace[0][c][33:32]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
